// File: rtl/fir_decim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fir_decim_sequencer
//  Purpose  : Time-multiplexed decimating FIR controller for one audio
//             channel. Incoming quantized samples are kept in a circular
//             history; every DECIM-th accepted sample triggers one pass of a
//             single shared multiply-accumulate over TAPS coefficients. The
//             accumulated result is dequantized (divide by 2^BITS, truncated
//             toward zero, wrapped to DATA_WIDTH) and presented downstream
//             with a valid/ready handshake.
//
//  Ports    :
//    clock         in   1            single clock domain
//    reset_n       in   1            asynchronous active-low reset
//    in_valid      in   1            input sample valid
//    in_ready      out  1            sequencer can accept a sample (IDLE)
//    in_data       in   DATA_WIDTH   signed quantized sample
//    coef_wr_en    in   1            coefficient write strobe (IDLE only)
//    coef_wr_addr  in   log2(TAPS)   coefficient index
//    coef_wr_data  in   DATA_WIDTH   signed quantized coefficient
//    out_valid     out  1            filtered output valid
//    out_ready     in   1            downstream accepts output
//    out_data      out  DATA_WIDTH   signed dequantized output
//    busy          out  1            high in any state other than IDLE
//
//  Revision : 1.0  initial release
// ============================================================================
module fir_decim_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = 32,   // power of two, at least 2
    parameter int DECIM      = 8,    // 1 = no decimation
    parameter int BITS       = 10    // quantization fraction bits
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_WIDTH-1:0]  in_data,
    input  logic                          coef_wr_en,
    input  logic        [$clog2(TAPS)-1:0] coef_wr_addr,
    input  logic signed [DATA_WIDTH-1:0]  coef_wr_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_WIDTH-1:0]  out_data,
    output logic                          busy
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    localparam int ADDR_W = $clog2(TAPS);
    localparam int PROD_W = 2 * DATA_WIDTH;
    // Headroom of log2(TAPS) bits so TAPS full-scale products cannot overflow
    localparam int ACC_W  = PROD_W + ADDR_W;
    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [ADDR_W-1:0] LAST_TAP  = ADDR_W'(TAPS - 1);
    localparam logic [DCNT_W-1:0] LAST_DCNT = DCNT_W'(DECIM - 1);

    // Added to a negative accumulator before the arithmetic shift so that the
    // shift truncates toward zero instead of toward minus infinity.
    localparam logic signed [ACC_W-1:0] ROUND_BIAS =
        {{(ACC_W - BITS){1'b0}}, {BITS{1'b1}}};

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_SCALE = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                       state;

    // ------------------------------------------------------------------------
    // Storage and datapath registers
    // ------------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] hist [TAPS];
    logic signed [DATA_WIDTH-1:0] coef [TAPS];
    logic        [ADDR_W-1:0]     wr_ptr;     // next history slot to write
    logic        [ADDR_W-1:0]     newest;     // slot of most recent sample
    logic        [DCNT_W-1:0]     dcnt;       // accepted samples since last compute
    logic        [ADDR_W-1:0]     tap_idx;    // MAC tap counter k
    logic signed [ACC_W-1:0]      acc;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic                         sample_fire;
    logic                         coef_fire;
    logic        [ADDR_W-1:0]     rd_idx;
    logic signed [DATA_WIDTH-1:0] hist_k;
    logic signed [DATA_WIDTH-1:0] coef_k;
    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_W-1:0]      prod_ext;
    logic signed [ACC_W-1:0]      acc_adj;

    // in_ready is high exactly in IDLE, so this is the IDLE handshake.
    assign sample_fire = in_valid & in_ready;
    // Coefficient writes are only honoured while no computation is running.
    assign coef_fire   = coef_wr_en & ~busy;

    // Subtraction in ADDR_W bits wraps modulo TAPS because TAPS is 2^ADDR_W.
    assign rd_idx   = newest - tap_idx;
    assign hist_k   = hist[rd_idx];
    assign coef_k   = coef[tap_idx];
    assign prod     = hist_k * coef_k;
    assign prod_ext = {{ADDR_W{prod[PROD_W-1]}}, prod};

    always_comb begin
        acc_adj = acc;
        if (acc[ACC_W-1]) begin
            acc_adj = acc + ROUND_BIAS;
        end
    end

    // ------------------------------------------------------------------------
    // Sample history and coefficient memories
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
                coef[i] <= '0;
            end
        end else begin
            if (sample_fire) begin
                hist[wr_ptr] <= in_data;
            end
            if (coef_fire) begin
                coef[coef_wr_addr] <= coef_wr_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered handshake and status outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            newest    <= '0;
            dcnt      <= '0;
            tap_idx   <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sample_fire) begin
                        newest <= wr_ptr;
                        wr_ptr <= wr_ptr + 1'b1;
                        if (dcnt == LAST_DCNT) begin
                            // Decimation point: start a fresh accumulation
                            dcnt     <= '0;
                            tap_idx  <= '0;
                            acc      <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= ST_MAC;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                end

                ST_MAC: begin
                    // k runs 0..TAPS-1, pairing coef[k] with the k-th newest sample
                    acc     <= acc + prod_ext;
                    tap_idx <= tap_idx + 1'b1;
                    if (tap_idx == LAST_TAP) begin
                        state <= ST_SCALE;
                    end
                end

                ST_SCALE: begin
                    // Wraps to DATA_WIDTH; no saturation on overflow
                    out_data  <= DATA_WIDTH'(acc_adj >>> BITS);
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end

                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_decim_sequencer
//  Purpose  : Self-checking bench for fir_decim_sequencer. Directed samples
//             with hand-computed expected outputs, a table of dequantization
//             vectors, and hand-written multi-cycle sequences for latency,
//             history wrap, backpressure, ignored coefficient writes and
//             reset during a computation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_decim_sequencer;

    localparam int DW    = 32;
    localparam int TAPS  = 32;
    localparam int DECIM = 8;
    localparam int BITS  = 10;
    localparam int AW    = 5;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_data = '0;
    logic                 coef_wr_en = 1'b0;
    logic        [AW-1:0] coef_wr_addr = '0;
    logic signed [DW-1:0] coef_wr_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] out_data;
    logic                 busy;

    fir_decim_sequencer #(
        .DATA_WIDTH (DW),
        .TAPS       (TAPS),
        .DECIM      (DECIM),
        .BITS       (BITS)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cyc   = 0;

    // Output monitor: every completed output handshake and every rising
    // edge of out_valid (with its cycle number) is logged.
    logic signed [DW-1:0] outq [$];
    int                   rise_q [$];
    logic                 prev_ov = 1'b0;

    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) outq.push_back(out_data);
        if (reset_n && out_valid && !prev_ov) rise_q.push_back(cyc);
        prev_ov <= out_valid;
    end

    typedef struct {
        logic signed [DW-1:0] sample;
        logic signed [DW-1:0] coef0;
        logic signed [DW-1:0] expect_out;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        coef_wr_en   = 1'b0;
        coef_wr_addr = '0;
        coef_wr_data = '0;
        out_ready    = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        outq.delete();
        rise_q.delete();
    endtask

    // Present one sample and hold it until it is accepted.
    task automatic send_sample(input logic signed [DW-1:0] v);
        bit ok;
        ok = 1'b0;
        @(posedge clock);
        #1;
        in_data  = v;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok     = 1'b1;
                hs_cyc = cyc;
                break;
            end
        end
        if (ok) begin
            @(posedge clock);
            #1;
        end else begin
            timeout_fail("in_ready wait");
        end
        in_valid = 1'b0;
    endtask

    // Write one coefficient once the sequencer is idle.
    task automatic write_coef(input logic [AW-1:0] a, input logic signed [DW-1:0] d);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("idle wait before coef write");
        coef_wr_en   = 1'b1;
        coef_wr_addr = a;
        coef_wr_data = d;
        @(posedge clock);
        #1 coef_wr_en = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (outq.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("output wait");
    endtask

    task automatic check_out(input string name, input int idx, input logic signed [DW-1:0] exp);
        if (outq.size() > idx) check(name, outq[idx], exp);
        else timeout_fail(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Dequantization table: coef[0] only, so output = sample*coef0/1024
        // truncated toward zero, wrapped to 32 bits.
        vecs[0] = '{sample: -32'sd1536,       coef0: 32'sd1,    expect_out: -32'sd1};
        vecs[1] = '{sample: 32'sd1536,        coef0: 32'sd1,    expect_out: 32'sd1};
        vecs[2] = '{sample: -32'sd1024,       coef0: 32'sd1,    expect_out: -32'sd1};
        vecs[3] = '{sample: -32'sd1023,       coef0: 32'sd1,    expect_out: 32'sd0};
        vecs[4] = '{sample: 32'sd1023,        coef0: 32'sd1,    expect_out: 32'sd0};
        vecs[5] = '{sample: -32'sd1,          coef0: 32'sd1,    expect_out: 32'sd0};
        vecs[6] = '{sample: 32'sd5,           coef0: 32'sd1024, expect_out: 32'sd5};
        vecs[7] = '{sample: -32'sd7,          coef0: 32'sd1024, expect_out: -32'sd7};
        // 2^30 * 2048 / 1024 = 2^31, which wraps to -2^31
        vecs[8] = '{sample: 32'sh4000_0000,   coef0: 32'sd2048, expect_out: 32'sh8000_0000};

        // ---------------- Reset values ----------------
        repeat (3) @(negedge clock);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset busy", busy, 0);

        // ---------------- Identity and latency ----------------
        do_reset();
        write_coef(0, 32'sd1024);
        for (int s = 1; s <= 7; s++) send_sample(DW'(s));
        repeat (40) @(negedge clock);
        check("identity no early output", outq.size(), 0);
        send_sample(32'sd8);
        @(negedge clock);
        check("identity busy in MAC", busy, 1);
        check("identity in_ready in MAC", in_ready, 0);
        wait_outputs(1);
        check_out("identity out_data", 0, 32'sd8);
        if (rise_q.size() > 0) check("identity latency", rise_q[0] - hs_cyc, 34);
        else timeout_fail("identity latency");
        repeat (40) @(negedge clock);
        check("identity single output", outq.size(), 1);

        // ---------------- Moving sum with history wrap ----------------
        do_reset();
        for (int a = 0; a < TAPS; a++) write_coef(AW'(a), 32'sd1024);
        for (int s = 0; s < 40; s++) send_sample(32'sd1024);
        wait_outputs(5);
        check_out("movsum out0", 0, 32'sd8192);
        check_out("movsum out1", 1, 32'sd16384);
        check_out("movsum out2", 2, 32'sd24576);
        check_out("movsum out3", 3, 32'sd32768);
        check_out("movsum out4 wrap", 4, 32'sd32768);

        // ---------------- Dequantization vector table ----------------
        do_reset();
        for (int v = 0; v < 9; v++) begin
            write_coef(0, vecs[v].coef0);
            for (int z = 0; z < DECIM - 1; z++) send_sample(32'sd0);
            send_sample(vecs[v].sample);
            wait_outputs(v + 1);
            check_out($sformatf("dequant vec%0d", v), v, vecs[v].expect_out);
        end

        // ---------------- Backpressure ----------------
        do_reset();
        write_coef(0, 32'sd1024);
        out_ready = 1'b0;
        for (int s = 1; s <= 8; s++) send_sample(DW'(s));
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clock);
                if (out_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) timeout_fail("bp out_valid wait");
        end
        for (int i = 0; i < 10; i++) begin
            check("bp out_valid held", out_valid, 1);
            check("bp out_data held", out_data, 8);
            check("bp in_ready low", in_ready, 0);
            check("bp busy high", busy, 1);
            @(negedge clock);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("bp out_valid dropped", out_valid, 0);
        check("bp in_ready back", in_ready, 1);
        check("bp busy cleared", busy, 0);
        check("bp single handshake", outq.size(), 1);
        check_out("bp out value", 0, 32'sd8);

        // ---------------- Coefficient write ignored while busy ----------------
        do_reset();
        write_coef(0, 32'sd1024);
        for (int s = 1; s <= 8; s++) send_sample(DW'(s));
        repeat (4) @(posedge clock);
        #1;
        coef_wr_en   = 1'b1;
        coef_wr_addr = '0;
        coef_wr_data = '0;
        @(negedge clock);
        check("cfg busy during write", busy, 1);
        @(posedge clock);
        #1 coef_wr_en = 1'b0;
        wait_outputs(1);
        check_out("cfg current output", 0, 32'sd8);
        for (int s = 9; s <= 16; s++) send_sample(DW'(s));
        wait_outputs(2);
        check_out("cfg coef kept", 1, 32'sd16);
        write_coef(0, 32'sd0);
        for (int s = 17; s <= 24; s++) send_sample(DW'(s));
        wait_outputs(3);
        check_out("cfg idle write zeroes", 2, 32'sd0);

        // ---------------- Reset during MAC ----------------
        do_reset();
        write_coef(0, 32'sd1024);
        for (int s = 1; s <= 8; s++) send_sample(DW'(s));
        repeat (5) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("rst busy", busy, 0);
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (50) @(negedge clock);
        check("rst no output", outq.size() + rise_q.size(), 0);
        for (int s = 0; s < 7; s++) send_sample(32'sd5);
        repeat (40) @(negedge clock);
        check("rst dcnt cleared", outq.size(), 0);
        send_sample(32'sd5);
        wait_outputs(1);
        check_out("rst coefs cleared", 0, 32'sd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_decim_sequencer.md
Name: fir_decim_sequencer

Overview:
- Time-multiplexed decimating FIR controller for the audio path.
- Buffers incoming quantized samples in a circular history and sequences one shared multiply-accumulate across TAPS coefficients.
- Computes a filter output only on every DECIM-th accepted sample, then dequantizes the result.
- Sits between the FM demodulator and the audio output stage; one instance serves one channel.

Parameters:
- DATA_WIDTH, 32: signed width of input samples, coefficients and output.
- TAPS, 32: filter length; power of two, equal to MAX_TAPS.
- DECIM, 8: decimation factor, equal to ADUIO_DECIM; 1 means no decimation.
- BITS, 10: quantization fraction bits; dequantize divides by 2^BITS.

Ports:
- clock  in  1  single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  sequencer can accept a sample.
- in_data  in  DATA_WIDTH  signed quantized sample.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  log2(TAPS)  coefficient index.
- coef_wr_data  in  DATA_WIDTH  signed quantized coefficient.
- out_valid  out  1  filtered output valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  DATA_WIDTH  signed dequantized output.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; sample history, coefficients, write pointer, decimation counter and accumulator all cleared to 0; in_ready=1, out_valid=0, out_data=0, busy=0. Reset asserted mid-MAC or mid-OUT aborts the operation and emits no output.
- States: IDLE, MAC, SCALE, OUT.
- IDLE: in_ready=1. An input handshake (in_valid & in_ready) writes in_data to hist[wr_ptr], latches newest=wr_ptr, and advances wr_ptr modulo TAPS (wraps TAPS-1 to 0).
  - If dcnt==DECIM-1: dcnt becomes 0 and state moves to MAC.
  - Otherwise dcnt increments and state stays IDLE.
- MAC: exactly TAPS cycles, k=0..TAPS-1. Each cycle: acc += coef[k] * hist[(newest-k) mod TAPS].
  - Products are 2*DATA_WIDTH signed.
  - acc is 2*DATA_WIDTH+log2(TAPS) signed and is cleared on MAC entry.
  - in_ready=0 throughout.
- SCALE: one cycle. out_data is loaded with acc / 2^BITS, truncated toward zero: add 2^BITS-1 when acc is negative, then arithmetic shift. The result is then truncated to the low DATA_WIDTH bits (wraps, no saturation). Enter OUT.
- OUT: out_valid=1 and out_data held stable until out_valid & out_ready; then out_valid drops and state returns to IDLE the next cycle. in_ready=0 while in OUT.
- Latency: DECIM-th sample accepted at cycle t; out_valid first high at cycle t+TAPS+2. Minimum spacing between accepted samples is 1 cycle except across a compute.
- Coefficient writes: take effect only when busy=0 (the same-cycle write lands before the next MAC). When busy=1 they are silently ignored. A write and a sample handshake may occur in the same IDLE cycle; both take effect.
- in_valid while in_ready=0: sample is not consumed; upstream must hold it.
- busy = (state != IDLE).

Test Plan:
- Identity: coef[0]=1024, others 0; feed samples 1..8 -> exactly one output. out_data=8, out_valid rises exactly 34 cycles after the 8th handshake, and no output follows samples 1..7.
- Moving sum with wrap: all 32 coefs=1024; feed 40 samples of 1024 -> five outputs: 8192, 16384, 24576, 32768, 32768. The 5th output proves wr_ptr wrap and overwrite of the oldest samples.
- Truncation toward zero: coef[0]=1; feed 7 zeros then -1536 -> out_data=-1, not -2. Same sequence with +1536 -> out_data=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, busy=1. Releasing out_ready gives one handshake; in_ready=1 the cycle after.
- Ignored config: during MAC, write coef[0]=0 (previously 1024) -> the current output is unaffected. A later identical write in IDLE zeroes the next output.
- Reset mid-MAC: assert reset_n=0 at MAC cycle 5 -> outputs return to reset values immediately with no out_valid. After release, 8 new samples are needed for the next output, and coefficients read as 0 (output 0).
